fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- RV32 instruction-fetch stage, directly upstream of instruction memory.
- Owns the program counter and drives the byte address into the instruction memory.
- Instruction memory reads asynchronously (combinational, word index = addr[31:2]).
- Captures the returned instruction into the IF/ID pipeline register for decode, with stall, redirect (branch/jump) and retired-fetch counting.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in id_instr when the slot is invalid.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard hold from decode; freezes PC and IF/ID.
- redirect_valid  in  1  taken branch/jump from execute.
- redirect_target  in  XLEN  new fetch byte address.
- imem_addr  out  XLEN  byte address to instruction memory; combinationally equal to pc.
- imem_instr  in  32  instruction word returned by memory in the same cycle.
- id_valid  out  1  IF/ID slot holds a real instruction.
- id_instr  out  32  registered instruction.
- id_pc  out  XLEN  address of id_instr.
- id_pc_plus4  out  XLEN  id_pc + 4, modulo 2^XLEN.
- fetch_count  out  32  number of instructions delivered to ID since reset.

Behaviour:
- All outputs except imem_addr are registered. imem_addr = pc with no added latency.
- Fetch-to-decode latency is 1 cycle: the word at imem_addr in cycle N appears on id_* after edge N.
- Reset values (rst high at the edge):
  - pc = RESET_PC; id_valid = 0; id_instr = NOP_INSTR; id_pc = 0; id_pc_plus4 = 0; fetch_count = 0.
  - After rst falls, the first edge captures the instruction at RESET_PC.
- Edge priority: rst > redirect_valid > stall > normal.
- Normal (no rst, no redirect, no stall):
  - pc <= pc + 4.
  - id_instr <= imem_instr; id_pc <= pc; id_pc_plus4 <= pc + 4.
  - id_valid <= 1; fetch_count <= fetch_count + 1.
- Redirect (overrides stall):
  - pc <= {redirect_target[XLEN-1:2], 2'b00}; low bits are silently cleared.
  - id_valid <= 0 and id_instr <= NOP_INSTR, because the in-flight fetch is wrong-path.
  - id_pc and id_pc_plus4 hold; fetch_count holds.
- Stall (no redirect): pc, all id_* and fetch_count hold their values; imem_addr stays constant.
- Arithmetic: PC increment wraps, so 32'hFFFF_FFFC + 4 = 32'h0000_0000. fetch_count wraps at 2^32.
- Redirect and stall asserted together: the redirect takes effect and the bubble is inserted. After the edge, a held stall continues to hold the bubble and the new pc.
- Reset mid-run overrides any stall or redirect in the same cycle. No partial state survives.
- Internal states:
  - BOOT: the IF/ID slot is empty after reset.
  - RUN: the slot has been filled at least once.
  - Transitions: BOOT -> RUN on the first normal edge; any state -> BOOT on rst.
  - The state is observable only through id_valid; it must not be an extra output.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN and NOP_INSTR constants.
  - fetch_state_e enum {BOOT, RUN}.
  - Packed struct if_id_t {valid, instr, pc, pc_plus4}, reused by decode.
- One natural sub-module, pc_reg: PC register with reset, hold, load-target and +4 increment.
- The IF/ID register, counter and state live in fetch_stage.

Test Plan:
- Memory preloaded with word i = 32'h1000_0000 + i. Release rst and run 3 cycles -> id_pc 0, 4, 8; id_instr 10000000, 10000001, 10000002; id_valid = 1; fetch_count = 3.
- Assert stall for 2 cycles at pc = 8 -> id_* and fetch_count frozen for both cycles; imem_addr = 8 throughout. Release stall -> next edge gives id_pc = 8.
- redirect_valid with target 32'h40 -> next edge id_valid = 0, id_instr = 00000013, imem_addr = 40. Following edge -> id_pc = 40, id_instr = 10000010.
- Redirect to 32'h43 while stall = 1 -> pc = 40 and id_valid = 0. Hold stall one more cycle -> no change.
- Force pc to FFFF_FFFC by redirect, then run 2 normal cycles -> id_pc = FFFF_FFFC, id_pc_plus4 = 0, then id_pc = 0.
- Assert rst mid-run together with redirect to 32'h80 -> pc = 0, id_valid = 0, fetch_count = 0 after the edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 pipeline constants and types
package riscv_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic            valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage control, imem and IF/ID bundle
interface fetch_stage_if #(
  parameter int XLEN = riscv_pkg::XLEN
);

  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_instr;
  logic            id_valid;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pc_plus4;
  logic [31:0]     fetch_count;

  modport master (
    input  stall,
    input  redirect_valid,
    input  redirect_target,
    output imem_addr,
    input  imem_instr,
    output id_valid,
    output id_instr,
    output id_pc,
    output id_pc_plus4,
    output fetch_count
  );

  modport slave (
    output stall,
    output redirect_valid,
    output redirect_target,
    input  imem_addr,
    output imem_instr,
    input  id_valid,
    input  id_instr,
    input  id_pc,
    input  id_pc_plus4,
    input  fetch_count
  );

endinterface

// File: rtl/fetch_stage_pc_reg.sv
// rtl/fetch_stage_pc_reg.sv - program counter with reset, hold, load and +4
module pc_reg #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            load,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc
);

  // load wins over hold so a redirect during a stall still steers fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= {target[XLEN-1:2], 2'b00};
    end else if (!hold) begin
      pc <= pc + XLEN'(4);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32 fetch stage: PC, IF/ID register and fetch counter
module fetch_stage #(
  parameter int              XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input logic          clk,
  input logic          rst,
  fetch_stage_if.master bus
);

  import riscv_pkg::*;

  logic [XLEN-1:0] pc;
  if_id_t          if_id_q;
  logic [31:0]     count_q;
  fetch_state_e    state_q;
  fetch_state_e    state_d;
  logic            do_fetch;
  logic            do_flush;

  pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .rst    (rst),
    .hold   (bus.stall),
    .load   (bus.redirect_valid),
    .target (bus.redirect_target),
    .pc     (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == BOOT && do_fetch) begin
      state_d = RUN;
    end
  end

  always_comb begin
    do_flush = bus.redirect_valid;
    do_fetch = !bus.redirect_valid && !bus.stall;
  end

  // redirect kills the in-flight word but keeps id_pc for debug visibility
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_q <= '{valid: 1'b0, instr: NOP_INSTR, pc: '0, pc_plus4: '0};
      count_q <= '0;
    end else if (do_flush) begin
      if_id_q.valid <= 1'b0;
      if_id_q.instr <= NOP_INSTR;
    end else if (do_fetch) begin
      if_id_q <= '{valid: 1'b1, instr: bus.imem_instr, pc: pc, pc_plus4: pc + XLEN'(4)};
      count_q <= count_q + 32'd1;
    end
  end

  assign bus.imem_addr   = pc;
  assign bus.id_valid    = if_id_q.valid;
  assign bus.id_instr    = if_id_q.instr;
  assign bus.id_pc       = if_id_q.pc;
  assign bus.id_pc_plus4 = if_id_q.pc_plus4;
  assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed bench for fetch_stage
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  int          checks;
  int          failures;
  logic [31:0] mem [0:255];

  fetch_stage_if #(.XLEN(32)) bus ();

  fetch_stage #(
    .XLEN      (32),
    .RESET_PC  (32'h0),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.imem_instr = mem[bus.imem_addr[9:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step(input logic s, input logic r, input logic [31:0] t, input logic rs);
    bus.stall           = s;
    bus.redirect_valid  = r;
    bus.redirect_target = t;
    rst                 = rs;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_id(input string tag, input logic v, input logic [31:0] ins,
                           input logic [31:0] pc, input logic [31:0] cnt, input logic [31:0] addr);
    check({tag, ".valid"}, {31'd0, bus.id_valid}, {31'd0, v});
    check({tag, ".instr"}, bus.id_instr, ins);
    check({tag, ".pc"}, bus.id_pc, pc);
    check({tag, ".count"}, bus.fetch_count, cnt);
    check({tag, ".addr"}, bus.imem_addr, addr);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    bus.stall           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    rst                 = 1'b1;
    @(negedge clk);

    step(0, 0, 0, 1);
    expect_id("reset", 0, 32'h13, 32'h0, 0, 32'h0);
    check("reset.plus4", bus.id_pc_plus4, 32'h0);

    step(0, 0, 0, 0);
    expect_id("run0", 1, 32'h1000_0000, 32'h0, 1, 32'h4);
    check("run0.plus4", bus.id_pc_plus4, 32'h4);
    step(0, 0, 0, 0);
    expect_id("run1", 1, 32'h1000_0001, 32'h4, 2, 32'h8);

    step(1, 0, 0, 0);
    expect_id("stall1", 1, 32'h1000_0001, 32'h4, 2, 32'h8);
    step(1, 0, 0, 0);
    expect_id("stall2", 1, 32'h1000_0001, 32'h4, 2, 32'h8);
    step(0, 0, 0, 0);
    expect_id("unstall", 1, 32'h1000_0002, 32'h8, 3, 32'hC);

    step(0, 1, 32'h40, 0);
    expect_id("redir", 0, 32'h13, 32'h8, 3, 32'h40);
    step(0, 0, 0, 0);
    expect_id("after_redir", 1, 32'h1000_0010, 32'h40, 4, 32'h44);

    step(1, 1, 32'h43, 0);
    expect_id("redir_stall", 0, 32'h13, 32'h40, 4, 32'h40);
    step(1, 0, 0, 0);
    expect_id("hold_bubble", 0, 32'h13, 32'h40, 4, 32'h40);

    step(0, 1, 32'hFFFF_FFFC, 0);
    check("wrap.addr", bus.imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    expect_id("wrap0", 1, 32'h1000_00FF, 32'hFFFF_FFFC, 5, 32'h0);
    check("wrap0.plus4", bus.id_pc_plus4, 32'h0);
    step(0, 0, 0, 0);
    expect_id("wrap1", 1, 32'h1000_0000, 32'h0, 6, 32'h4);
    check("wrap1.plus4", bus.id_pc_plus4, 32'h4);

    step(1, 1, 32'h80, 1);
    expect_id("midrst", 0, 32'h13, 32'h0, 0, 32'h0);
    check("midrst.plus4", bus.id_pc_plus4, 32'h0);
    step(0, 0, 0, 0);
    expect_id("reboot", 1, 32'h1000_0000, 32'h0, 1, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
